// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port data RAM between the processor
// (port P) and the debug/DMA loader (port D). Conflicts are resolved
// round-robin. A master may hold the RAM for a locked burst of up to
// MAX_BURST consecutive grants. Read data returns one cycle after the grant.
// Optional feature macro: DMEM_ARB_PERF_EN adds saturating performance
// counters (perf_p_gnt, perf_d_gnt, perf_conflict).
module dmem_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic              p_lock,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut,
  output logic              stall_p
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_p_gnt,
  output logic [CNT_W-1:0]  perf_d_gnt,
  output logic [CNT_W-1:0]  perf_conflict
`endif
);

  // The burst counter needs at least one bit even when MAX_BURST is 1.
  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  // Reject parameter values that make the arbiter meaningless.
  if (MAX_BURST < 1 || CNT_W < 1) begin : g_bad_param
    $error("dmem_port_arbiter: MAX_BURST and CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_P = 2'd1,
    OWN_D = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic                last_was_p_q, last_was_p_d;
  logic                p_rvalid_q, p_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   p_rdata_q, p_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                gnt_p, gnt_d;
  logic                p_keep, d_keep;

  // Grant decision: a locked owner with burst budget left keeps the RAM,
  // otherwise a sole requester wins and a tie goes to the port not served last.
  always_comb begin
    p_keep = (state_q == OWN_P) && p_req && p_lock && (burst_cnt_q < BURST_LAST);
    d_keep = (state_q == OWN_D) && d_req && d_lock && (burst_cnt_q < BURST_LAST);
    gnt_p  = 1'b0;
    gnt_d  = 1'b0;
    if (p_keep) begin
      gnt_p = 1'b1;
    end else if (d_keep) begin
      gnt_d = 1'b1;
    end else if (p_req && d_req) begin
      if (last_was_p_q) begin
        gnt_d = 1'b1;
      end else begin
        gnt_p = 1'b1;
      end
    end else if (p_req) begin
      gnt_p = 1'b1;
    end else if (d_req) begin
      gnt_d = 1'b1;
    end
  end

  // Next ownership, burst length, round-robin pointer and read-return capture.
  always_comb begin
    state_d      = IDLE;
    burst_cnt_d  = '0;
    last_was_p_d = last_was_p_q;
    if (gnt_p && p_lock) begin
      state_d = OWN_P;
    end else if (gnt_d && d_lock) begin
      state_d = OWN_D;
    end
    // Counting only continues while the same master stays owner; it
    // saturates so a lone owner re-granted past its budget cannot wrap
    // into a fresh locked burst.
    if (state_d != IDLE && state_d == state_q) begin
      burst_cnt_d = (burst_cnt_q == BURST_LAST) ? burst_cnt_q : burst_cnt_q + 1'b1;
    end
    if (gnt_p) begin
      last_was_p_d = 1'b1;
    end else if (gnt_d) begin
      last_was_p_d = 1'b0;
    end
    p_rvalid_d = gnt_p && !p_we;
    d_rvalid_d = gnt_d && !d_we;
    p_rdata_d  = p_rdata;
    d_rdata_d  = d_rdata;
  end

  // All arbiter state; reset leaves P as winner of the first tie and drops
  // any read return still in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      last_was_p_q <= 1'b0;
      p_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      p_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_was_p_q <= last_was_p_d;
      p_rvalid_q   <= p_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      p_rdata_q    <= p_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // RAM data appears the cycle after the address, so a valid return passes
  // ram_dataOut straight through and otherwise the last returned word is held.
  assign p_gnt      = gnt_p;
  assign d_gnt      = gnt_d;
  assign stall_p    = p_req && !gnt_p;
  assign p_rvalid   = p_rvalid_q;
  assign d_rvalid   = d_rvalid_q;
  assign p_rdata    = p_rvalid_q ? ram_dataOut : p_rdata_q;
  assign d_rdata    = d_rvalid_q ? ram_dataOut : d_rdata_q;
  assign ram_addr   = gnt_d ? d_addr : p_addr;
  assign ram_dataIn = gnt_d ? d_wdata : p_wdata;
  assign ram_wEn    = reset && ((gnt_p && p_we) || (gnt_d && d_we));

`ifdef DMEM_ARB_PERF_EN
  logic [CNT_W-1:0] perf_p_gnt_q, perf_p_gnt_d;
  logic [CNT_W-1:0] perf_d_gnt_q, perf_d_gnt_d;
  logic [CNT_W-1:0] perf_conflict_q, perf_conflict_d;

  // Saturating event counters for grants per port and contended cycles.
  always_comb begin
    perf_p_gnt_d    = perf_p_gnt_q;
    perf_d_gnt_d    = perf_d_gnt_q;
    perf_conflict_d = perf_conflict_q;
    if (gnt_p && perf_p_gnt_q != '1) begin
      perf_p_gnt_d = perf_p_gnt_q + 1'b1;
    end
    if (gnt_d && perf_d_gnt_q != '1) begin
      perf_d_gnt_d = perf_d_gnt_q + 1'b1;
    end
    if (p_req && d_req && perf_conflict_q != '1) begin
      perf_conflict_d = perf_conflict_q + 1'b1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_p_gnt_q    <= '0;
      perf_d_gnt_q    <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_p_gnt_q    <= perf_p_gnt_d;
      perf_d_gnt_q    <= perf_d_gnt_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_p_gnt    = perf_p_gnt_q;
  assign perf_d_gnt    = perf_d_gnt_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: directed steps with a read-return
// scoreboard and a behavioural single-port RAM. Counter checks are included
// when DMEM_ARB_PERF_EN is defined.
module tb_dmem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        p_req, p_we, p_lock;
  logic [11:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_gnt, p_rvalid;
  logic [31:0] p_rdata;
  logic        d_req, d_we, d_lock;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn;
  logic [31:0] ram_dataOut;
  logic        stall_p;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_p_gnt, perf_d_gnt, perf_conflict;
`endif

  int vectors;
  int miscompares;

  typedef struct packed {
    logic        is_p;
    logic [31:0] data;
  } ret_t;

  ret_t        ret_q[$];
  logic [31:0] p_hold_exp;
  logic [31:0] d_hold_exp;
  logic [31:0] ram_mem   [0:4095];
  logic [31:0] model_mem [0:4095];

  dmem_port_arbiter #(
    .ADDR_W(12), .DATA_W(32), .MAX_BURST(4), .CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_lock(p_lock), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut), .stall_p(stall_p)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_p_gnt(perf_p_gnt), .perf_d_gnt(perf_d_gnt), .perf_conflict(perf_conflict)
`endif
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural RAM: registered read of the presented address, write on wEn.
  always @(posedge clock) begin
    ram_dataOut <= ram_mem[ram_addr];
    if (ram_wEn) ram_mem[ram_addr] = ram_dataIn;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One cycle: drive inputs at negedge, check grants, the read return from
  // the previous cycle, and RAM muxing; then record the expected effect.
  task automatic applyStimulus(
    input logic preq, input logic pwe, input logic plock,
    input logic [11:0] paddr, input logic [31:0] pwd,
    input logic dreq, input logic dwe, input logic dlock,
    input logic [11:0] daddr, input logic [31:0] dwd,
    input logic exp_p, input logic exp_d, input string tag);
    ret_t r;
    logic exp_pv, exp_dv;
    @(negedge clock);
    p_req = preq; p_we = pwe; p_lock = plock; p_addr = paddr; p_wdata = pwd;
    d_req = dreq; d_we = dwe; d_lock = dlock; d_addr = daddr; d_wdata = dwd;
    #1;
    exp_pv = 1'b0;
    exp_dv = 1'b0;
    if (ret_q.size() > 0) begin
      r = ret_q.pop_front();
      if (r.is_p) begin
        exp_pv = 1'b1;
        p_hold_exp = r.data;
      end else begin
        exp_dv = 1'b1;
        d_hold_exp = r.data;
      end
    end
    checkOutput({tag, ".p_rvalid"}, {31'd0, p_rvalid}, {31'd0, exp_pv});
    checkOutput({tag, ".p_rdata"}, p_rdata, p_hold_exp);
    checkOutput({tag, ".d_rvalid"}, {31'd0, d_rvalid}, {31'd0, exp_dv});
    checkOutput({tag, ".d_rdata"}, d_rdata, d_hold_exp);
    checkOutput({tag, ".p_gnt"}, {31'd0, p_gnt}, {31'd0, exp_p});
    checkOutput({tag, ".d_gnt"}, {31'd0, d_gnt}, {31'd0, exp_d});
    checkOutput({tag, ".stall_p"}, {31'd0, stall_p}, {31'd0, preq & ~exp_p});
    checkOutput({tag, ".ram_wEn"}, {31'd0, ram_wEn}, {31'd0, (exp_p & pwe) | (exp_d & dwe)});
    if (exp_p) begin
      checkOutput({tag, ".ram_addr"}, {20'd0, ram_addr}, {20'd0, paddr});
      if (pwe) begin
        checkOutput({tag, ".ram_dataIn"}, ram_dataIn, pwd);
        model_mem[paddr] = pwd;
      end else begin
        ret_q.push_back('{is_p: 1'b1, data: model_mem[paddr]});
      end
    end
    if (exp_d) begin
      checkOutput({tag, ".ram_addr"}, {20'd0, ram_addr}, {20'd0, daddr});
      if (dwe) begin
        checkOutput({tag, ".ram_dataIn"}, ram_dataIn, dwd);
        model_mem[daddr] = dwd;
      end else begin
        ret_q.push_back('{is_p: 1'b0, data: model_mem[daddr]});
      end
    end
  endtask

  task automatic idleStep(input string tag);
    applyStimulus(0, 0, 0, 12'h0, 32'h0, 0, 0, 0, 12'h0, 32'h0, 0, 0, tag);
  endtask

  // Holds reset for two cycles, checks the cleared outputs, then releases.
  task automatic doReset(input string tag);
    reset = 1'b0;
    p_req = 0; p_we = 0; p_lock = 0; p_addr = '0; p_wdata = '0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clock);
    #1;
    checkOutput({tag, ".p_rvalid"}, {31'd0, p_rvalid}, 32'd0);
    checkOutput({tag, ".d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
    checkOutput({tag, ".p_rdata"}, p_rdata, 32'd0);
    checkOutput({tag, ".d_rdata"}, d_rdata, 32'd0);
    checkOutput({tag, ".ram_wEn"}, {31'd0, ram_wEn}, 32'd0);
    ret_q.delete();
    p_hold_exp = '0;
    d_hold_exp = '0;
    reset = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    p_hold_exp = '0;
    d_hold_exp = '0;
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i]   = 32'hA500_0000 | i;
      model_mem[i] = 32'hA500_0000 | i;
    end
    ram_mem[12'h010]   = 32'hDEAD_BEEF;
    model_mem[12'h010] = 32'hDEAD_BEEF;

    doReset("reset");

    // Single P read returns the next cycle.
    applyStimulus(1, 0, 0, 12'h010, 32'h0, 0, 0, 0, 12'h0, 32'h0, 1, 0, "t1.read");
    idleStep("t1.ret");

    // D alone leaves the round-robin pointer on D.
    applyStimulus(0, 0, 0, 12'h0, 32'h0, 1, 0, 0, 12'h020, 32'h0, 0, 1, "solo_d");

    // Both masters reading every cycle alternate P, D, P, D...
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 12'(12'h100 + (i + 1) / 2), 32'h0,
                    1, 0, 0, 12'(12'h300 + i / 2), 32'h0,
                    (i % 2) == 0, (i % 2) == 1, $sformatf("t2.rr%0d", i));
    end
    idleStep("t2.ret");

    // P served last, then a locked D burst contends with a waiting P read.
    applyStimulus(1, 0, 0, 12'h011, 32'h0, 0, 0, 0, 12'h0, 32'h0, 1, 0, "t3.pre");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0, 12'h010, 32'h0, 1, 1, 1, 12'(12'h200 + k), 32'hD000_0000 | k,
                    0, 1, $sformatf("t3.burst%0d", k));
    end
    applyStimulus(1, 0, 0, 12'h010, 32'h0, 1, 1, 1, 12'h204, 32'hD000_0004, 1, 0, "t3.p_turn");
    applyStimulus(0, 0, 0, 12'h0, 32'h0, 1, 1, 1, 12'h204, 32'hD000_0004, 0, 1, "t3.d_again");
    applyStimulus(1, 0, 0, 12'h012, 32'h0, 0, 0, 0, 12'h0, 32'h0, 1, 0, "t3.owner_drop");
    applyStimulus(1, 0, 0, 12'h200, 32'h0, 0, 0, 0, 12'h0, 32'h0, 1, 0, "t3.rd200");
    applyStimulus(1, 0, 0, 12'h204, 32'h0, 0, 0, 0, 12'h0, 32'h0, 1, 0, "t3.rd204");
    idleStep("t3.ret");

    // D write then P read of the same word.
    applyStimulus(0, 0, 0, 12'h0, 32'h0, 1, 1, 0, 12'h123, 32'h0000_0005, 0, 1, "t4.dwrite");
    applyStimulus(1, 0, 0, 12'h123, 32'h0, 0, 0, 0, 12'h0, 32'h0, 1, 0, "t4.pread");
    idleStep("t4.ret");

    // Reset right after a granted P read: the return never appears.
    applyStimulus(1, 0, 0, 12'h050, 32'h0, 0, 0, 0, 12'h0, 32'h0, 1, 0, "t5.read");
    #2;
    reset = 1'b0;
    p_req = 1; p_we = 1; p_addr = 12'h050; p_wdata = 32'h0000_0BAD;
    #1;
    checkOutput("t5.wen_in_reset", {31'd0, ram_wEn}, 32'd0);
    ret_q.delete();
    @(posedge clock);
    #1;
    checkOutput("t5.no_rvalid", {31'd0, p_rvalid}, 32'd0);
    @(negedge clock);
    checkOutput("t5.no_rvalid2", {31'd0, p_rvalid}, 32'd0);
    checkOutput("t5.rdata_clr", p_rdata, 32'd0);
    p_req = 0; p_we = 0;
    p_hold_exp = '0;
    d_hold_exp = '0;
    reset = 1'b1;
    applyStimulus(1, 0, 0, 12'h051, 32'h0, 1, 0, 0, 12'h052, 32'h0, 1, 0, "t5.first_tie");
    idleStep("t5.ret");

`ifdef DMEM_ARB_PERF_EN
    // Ten contended cycles split evenly between the ports.
    doReset("t6.reset");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, 12'h060, 32'h0, 1, 0, 0, 12'h070, 32'h0,
                    (i % 2) == 0, (i % 2) == 1, $sformatf("t6.c%0d", i));
    end
    idleStep("t6.ret");
    checkOutput("t6.perf_conflict", {16'd0, perf_conflict}, 32'd10);
    checkOutput("t6.perf_p_gnt", {16'd0, perf_p_gnt}, 32'd5);
    checkOutput("t6.perf_d_gnt", {16'd0, perf_d_gnt}, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
